// File: rtl/n64_cmd_deserializer.sv
// n64_cmd_deserializer
//   Packs bits from the N64 line decoder into bytes, MSB first. Reports each byte, the
//   command byte (byte 0) and a per-frame summary. All decoder outputs are synchronized
//   into i_clk before use.
//
// Ports:
//   i_clk            system clock (at least 4x the decoder sample clock)
//   i_reset_n        asynchronous active-low reset
//   i_cur_operation  0 = Rx (events acted on), 1 = Tx (events discarded, state frozen)
//   i_derived_signal recovered bit value
//   i_derived_clk    bit strobe, idles high, low for one sample period per bit
//   i_tx_handoff     toggles once per frame end
//   o_byte_data      most recently completed byte
//   o_byte_valid     one-cycle pulse when o_byte_data updates
//   o_byte_idx       index of o_byte_data within the frame (0 = command)
//   o_cmd_byte       byte 0 of the current or last frame
//   o_busy           high while a frame is being received
//   o_frame_done     one-cycle pulse at frame end
//   o_frame_bytes    bytes stored in the last frame (saturates at MAX_BYTES)
//   o_frame_err      valid with o_frame_done: partial byte, empty frame or overflow
module n64_cmd_deserializer #(
  parameter int unsigned MAX_BYTES   = 35,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cur_operation,
  input  logic       i_derived_signal,
  input  logic       i_derived_clk,
  input  logic       i_tx_handoff,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic [5:0] o_byte_idx,
  output logic [7:0] o_cmd_byte,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [5:0] o_frame_bytes,
  output logic       o_frame_err
);

  localparam logic [5:0] LP_MAX = 6'(MAX_BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } state_e;

  // Synchronizers: all three inputs share one pipeline so the stop-bit strobe and the
  // handoff toggle stay aligned.
  logic [SYNC_STAGES-1:0] r_clk_s;
  logic [SYNC_STAGES-1:0] r_sig_s;
  logic [SYNC_STAGES-1:0] r_ho_s;
  logic                   r_clk_h;
  logic                   r_ho_h;
  logic                   r_primed;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_clk_s  <= '1;
      r_sig_s  <= '1;
      r_ho_s   <= '0;
      r_clk_h  <= 1'b1;
      r_ho_h   <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_clk_s <= {r_clk_s[SYNC_STAGES-2:0], i_derived_clk};
      r_sig_s <= {r_sig_s[SYNC_STAGES-2:0], i_derived_signal};
      r_clk_h <= r_clk_s[SYNC_STAGES-1];
      if (!r_primed) begin
        // First cycle after reset: preload the handoff chain with the live level so the
        // current toggle state is never mistaken for a frame end.
        r_ho_s   <= {SYNC_STAGES{i_tx_handoff}};
        r_ho_h   <= i_tx_handoff;
        r_primed <= 1'b1;
      end else begin
        r_ho_s <= {r_ho_s[SYNC_STAGES-2:0], i_tx_handoff};
        r_ho_h <= r_ho_s[SYNC_STAGES-1];
      end
    end
  end

  logic w_bit;
  logic w_bit_evt;
  logic w_frame_evt;

  always_comb begin
    w_bit       = r_sig_s[SYNC_STAGES-1];
    w_bit_evt   = r_clk_h & ~r_clk_s[SYNC_STAGES-1] & ~i_cur_operation;
    w_frame_evt = r_primed & (r_ho_h ^ r_ho_s[SYNC_STAGES-1]) & ~i_cur_operation;
  end

  // Frame FSM and registered outputs
  state_e     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [5:0] r_byte_cnt;
  logic       r_ovf;
  logic       r_byte_pend;
  logic [5:0] r_pend_idx;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_ovf         <= 1'b0;
      r_byte_pend   <= 1'b0;
      r_pend_idx    <= '0;
      o_byte_data   <= '0;
      o_byte_valid  <= 1'b0;
      o_byte_idx    <= '0;
      o_cmd_byte    <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_bytes <= '0;
      o_frame_err   <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_done <= 1'b0;

      // Byte report lags the 8th-bit shift by one cycle; the counter was already
      // advanced at the shift, so the index is carried separately.
      if (r_byte_pend) begin
        r_byte_pend  <= 1'b0;
        o_byte_valid <= 1'b1;
        o_byte_data  <= r_shift;
        o_byte_idx   <= r_pend_idx;
        if (r_pend_idx == 6'd0) begin
          o_cmd_byte <= r_shift;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_frame_evt) begin
            // Empty frame (a simultaneous strobe is the stop bit and is dropped)
            r_state <= StDone;
          end else if (w_bit_evt) begin
            r_shift   <= {r_shift[6:0], w_bit};
            r_bit_cnt <= 3'd1;
            r_state   <= StRecv;
            o_busy    <= 1'b1;
          end
        end
        StRecv: begin
          if (w_frame_evt) begin
            // Any strobe in this cycle is the stop bit: not shifted
            r_state <= StDone;
            o_busy  <= 1'b0;
          end else if (w_bit_evt) begin
            r_shift   <= {r_shift[6:0], w_bit};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_byte_cnt < LP_MAX) begin
                r_byte_pend <= 1'b1;
                r_pend_idx  <= r_byte_cnt;
                r_byte_cnt  <= r_byte_cnt + 6'd1;
              end else begin
                r_ovf <= 1'b1;
              end
            end
          end
        end
        StDone: begin
          o_frame_done  <= 1'b1;
          o_frame_bytes <= r_byte_cnt;
          o_frame_err   <= (r_bit_cnt != 3'd0) | (r_byte_cnt == 6'd0) | r_ovf;
          r_bit_cnt     <= '0;
          r_byte_cnt    <= '0;
          r_ovf         <= 1'b0;
          r_state       <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_cmd_deserializer.sv
module tb_n64_cmd_deserializer;

  localparam int MaxBytes = 35;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cur_operation = 1'b0;
  logic       derived_signal = 1'b1;
  logic       derived_clk = 1'b1;
  logic       tx_handoff = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [5:0] byte_idx;
  logic [7:0] cmd_byte;
  logic       busy;
  logic       frame_done;
  logic [5:0] frame_bytes;
  logic       frame_err;

  n64_cmd_deserializer #(
    .MAX_BYTES  (35),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_cur_operation (cur_operation),
    .i_derived_signal(derived_signal),
    .i_derived_clk   (derived_clk),
    .i_tx_handoff    (tx_handoff),
    .o_byte_data     (byte_data),
    .o_byte_valid    (byte_valid),
    .o_byte_idx      (byte_idx),
    .o_cmd_byte      (cmd_byte),
    .o_busy          (busy),
    .o_frame_done    (frame_done),
    .o_frame_bytes   (frame_bytes),
    .o_frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bits of the frame about to be sent, in wire order
  logic tx_bits[$];
  logic [7:0] exp_cmd = 8'h00;

  // Monitor: only appends, tests compare the tail since their start
  logic [7:0] cap_data[$];
  int         cap_idx[$];
  int         cap_fb[$];
  logic       cap_fe[$];
  int         overlap = 0;
  int         busy_hi = 0;

  always @(negedge clk) begin
    if (byte_valid) begin
      cap_data.push_back(byte_data);
      cap_idx.push_back(int'(byte_idx));
    end
    if (frame_done) begin
      cap_fb.push_back(int'(frame_bytes));
      cap_fe.push_back(frame_err);
    end
    if (byte_valid && frame_done) overlap++;
    if (busy) busy_hi++;
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    derived_signal = b;
    derived_clk = 1'b0;
    repeat (4) @(negedge clk);
    derived_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Stop bit strobe together with the end-of-frame toggle
  task automatic drive_stop();
    @(negedge clk);
    derived_signal = 1'b1;
    derived_clk = 1'b0;
    tx_handoff = ~tx_handoff;
    repeat (4) @(negedge clk);
    derived_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int j = 7; j >= 0; j--) tx_bits.push_back(v[j]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tx_handoff = 1'b1;  // nonzero level at release must not look like a toggle
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_data, byte_valid, byte_idx, cmd_byte, busy, frame_done, frame_bytes, frame_err}
        !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%0d/%h/%b/%b/%0d/%b required all zero",
               byte_data, byte_valid, byte_idx, cmd_byte, busy, frame_done, frame_bytes,
               frame_err);
    end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (cap_fb.size() != 0 || cap_data.size() != 0) begin
      errors++;
      $display("FAIL reset_release_quiet: got %0d frame_done %0d byte_valid required 0 0",
               cap_fb.size(), cap_data.size());
    end
  endtask

  // Sends tx_bits plus stop and checks against the frame rules
  task automatic test_frame(input string name);
    int b0, f0, o0, n, nfull, nexp;
    logic [7:0] e;
    logic eerr;
    b0 = cap_data.size();
    f0 = cap_fb.size();
    o0 = overlap;
    n = tx_bits.size();
    foreach (tx_bits[i]) drive_bit(tx_bits[i]);
    drive_stop();
    repeat (6) @(negedge clk);
    nfull = n / 8;
    nexp = (nfull > MaxBytes) ? MaxBytes : nfull;
    eerr = (n % 8 != 0) || (nfull == 0) || (nfull > MaxBytes);
    checks++;
    if (cap_data.size() - b0 != nexp) begin
      errors++;
      $display("FAIL %s byte_count: got %0d required %0d", name, cap_data.size() - b0, nexp);
    end
    for (int k = 0; k < nexp && b0 + k < cap_data.size(); k++) begin
      e = 8'h00;
      for (int j = 0; j < 8; j++) e = {e[6:0], tx_bits[8 * k + j]};
      if (k == 0) exp_cmd = e;
      checks++;
      if (cap_data[b0 + k] !== e || cap_idx[b0 + k] != k) begin
        errors++;
        $display("FAIL %s byte%0d: got %h idx %0d required %h idx %0d", name, k,
                 cap_data[b0 + k], cap_idx[b0 + k], e, k);
      end
    end
    checks++;
    if (cmd_byte !== exp_cmd) begin
      errors++;
      $display("FAIL %s cmd_byte: got %h required %h", name, cmd_byte, exp_cmd);
    end
    checks++;
    if (cap_fb.size() - f0 != 1) begin
      errors++;
      $display("FAIL %s frame_done_count: got %0d required 1", name, cap_fb.size() - f0);
    end else begin
      checks++;
      if (cap_fb[f0] != nexp || cap_fe[f0] !== eerr) begin
        errors++;
        $display("FAIL %s frame_summary: got bytes %0d err %b required bytes %0d err %b",
                 name, cap_fb[f0], cap_fe[f0], nexp, eerr);
      end
    end
    checks++;
    if (overlap != o0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s overlap_busy: got overlap %0d busy %b required 0 0", name,
               overlap - o0, busy);
    end
  endtask

  task automatic test_directed_frames();
    tx_bits = {};
    push_byte(8'h00);
    test_frame("single_00");
    tx_bits = {};
    push_byte(8'h02); push_byte(8'h80); push_byte(8'h1F);
    test_frame("three_bytes");
    tx_bits = {};
    push_byte(8'hFF);
    tx_bits.push_back(1'b1); tx_bits.push_back(1'b0); tx_bits.push_back(1'b1);
    test_frame("eleven_bits");
    tx_bits = {};
    for (int i = 0; i < MaxBytes + 2; i++) push_byte(8'hA5);
    test_frame("overflow");
    tx_bits = {};
    push_byte(8'h5A);
    test_frame("after_overflow");
  endtask

  task automatic test_random_frames();
    int n;
    for (int r = 0; r < 10; r++) begin
      n = ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(1, 6) : $urandom_range(0, 50);
      tx_bits = {};
      for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
      test_frame("random");
    end
  endtask

  // Handoff toggle with no strobe at all (decoder timeout path)
  task automatic test_empty_frame();
    int f0;
    f0 = cap_fb.size();
    @(negedge clk);
    tx_handoff = ~tx_handoff;
    repeat (8) @(negedge clk);
    checks++;
    if (cap_fb.size() - f0 != 1) begin
      errors++;
      $display("FAIL empty_frame_count: got %0d required 1", cap_fb.size() - f0);
    end else begin
      checks++;
      if (cap_fb[f0] != 0 || cap_fe[f0] !== 1'b1) begin
        errors++;
        $display("FAIL empty_frame_summary: got bytes %0d err %b required 0 1",
                 cap_fb[f0], cap_fe[f0]);
      end
    end
  endtask

  task automatic test_tx_mode();
    int b0, f0, bh;
    logic [7:0] e;
    b0 = cap_data.size();
    f0 = cap_fb.size();
    bh = busy_hi;
    cur_operation = 1'b1;
    for (int i = 0; i < 16; i++) drive_bit(1'($urandom_range(0, 1)));
    drive_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (cap_data.size() != b0 || cap_fb.size() != f0 || busy_hi != bh) begin
      errors++;
      $display("FAIL tx_ignored: got bytes %0d frames %0d busy cycles %0d required 0 0 0",
               cap_data.size() - b0, cap_fb.size() - f0, busy_hi - bh);
    end
    // Freeze mid-frame: the Tx-period strobes and toggle must not disturb the byte
    cur_operation = 1'b0;
    e = 8'($urandom_range(0, 255));
    for (int j = 7; j >= 4; j--) drive_bit(e[j]);
    cur_operation = 1'b1;
    for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)));
    drive_stop();
    cur_operation = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL freeze_busy: got %b required 1", busy);
    end
    for (int j = 3; j >= 0; j--) drive_bit(e[j]);
    drive_stop();
    repeat (6) @(negedge clk);
    exp_cmd = e;
    checks++;
    if (cap_data.size() - b0 != 1 || cap_fb.size() - f0 != 1) begin
      errors++;
      $display("FAIL freeze_counts: got bytes %0d frames %0d required 1 1",
               cap_data.size() - b0, cap_fb.size() - f0);
    end else begin
      checks++;
      if (cap_data[b0] !== e || cap_fb[f0] != 1 || cap_fe[f0] !== 1'b0 || cmd_byte !== e) begin
        errors++;
        $display("FAIL freeze_frame: got %h bytes %0d err %b cmd %h required %h 1 0 %h",
                 cap_data[b0], cap_fb[f0], cap_fe[f0], cmd_byte, e, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    f0 = cap_fb.size();
    tx_bits = {};
    push_byte(8'hC7);
    for (int i = 0; i < 5; i++) tx_bits.push_back(1'b1);
    foreach (tx_bits[i]) drive_bit(tx_bits[i]);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_data, byte_valid, byte_idx, cmd_byte, busy, frame_done, frame_bytes, frame_err}
        !== 32'h0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h/%b/%0d/%h/%b/%b/%0d/%b required all zero",
               byte_data, byte_valid, byte_idx, cmd_byte, busy, frame_done, frame_bytes,
               frame_err);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_cmd = 8'h00;
    checks++;
    if (cap_fb.size() != f0) begin
      errors++;
      $display("FAIL midframe_no_done: got %0d frame_done required 0", cap_fb.size() - f0);
    end
    tx_bits = {};
    push_byte(8'h01);
    test_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_directed_frames();
    test_empty_frame();
    test_random_frames();
    test_tx_mode();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
